// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the NBBPU data bus: a TX FIFO feeds a bit serializer.
// Define MMIO_UART_TX_IRQ_EN to add the irq output and the IRQ_ENABLE bit (STATUS write bit 4).
module mmio_uart_tx #(
   parameter int          FIFO_DEPTH      = 8,
   parameter logic [15:0] DEFAULT_DIVISOR = 16'd103
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        select,
   input  logic        read_enable,
   input  logic        write_enable,
   input  logic [15:0] address,
   input  logic [15:0] write_data,
   output logic [15:0] read_data,
   output logic        tx
`ifdef MMIO_UART_TX_IRQ_EN
   ,
   output logic        irq
`endif
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            overflow_q, overflow_d;
   logic [15:0]     divisor_q, divisor_d;
   logic [15:0]     bit_div_q, bit_div_d;
   logic [15:0]     div_cnt_q, div_cnt_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      shift_q, shift_d;
   logic            tx_q, tx_d;
   logic [15:0]     read_data_q, read_data_d;
   logic [7:0]      fifo_mem [FIFO_DEPTH];

   logic            bus_rd, bus_wr, push, pop, push_ok, full, empty, bit_end, irq_en_bit;
   logic [4:0]      count_ext;
   logic [15:0]     status_word;
   logic            unused_addr;

   assign unused_addr = ^address[15:2];

   assign bus_rd    = select & read_enable;
   assign bus_wr    = select & write_enable;
   assign full      = (count_q == CW'(FIFO_DEPTH));
   assign empty     = (count_q == '0);
   assign push      = bus_wr && (address[1:0] == 2'd0);
   assign pop       = (state_q == S_IDLE) && !empty;
   // A push into a full FIFO still lands if the serializer pops on the same edge.
   assign push_ok   = push && (!full || pop);
   assign count_ext = 5'(count_q);

`ifdef MMIO_UART_TX_IRQ_EN
   logic irq_en_q, irq_en_d, irq_q;
   assign irq_en_bit = irq_en_q;
   assign irq        = irq_q;
   always_comb begin
      irq_en_d = irq_en_q;
      if (bus_wr && (address[1:0] == 2'd1)) irq_en_d = write_data[4];
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         irq_en_q <= irq_en_d;
         irq_q    <= irq_en_q && (state_q == S_IDLE) && empty;
      end
   end
`else
   assign irq_en_bit = 1'b0;
`endif

   assign status_word = {3'b000, count_ext, 3'b000, irq_en_bit, overflow_q, empty, full,
                         (state_q != S_IDLE)};

   // Bus side: FIFO pointers, sticky overflow, divisor register and registered read data.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      divisor_d   = divisor_q;
      read_data_d = read_data_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_ok, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (bus_rd && (address[1:0] == 2'd1)) overflow_d = 1'b0;
      if (push && !push_ok)                 overflow_d = 1'b1;
      if (bus_wr && (address[1:0] == 2'd2)) divisor_d = write_data;
      if (bus_rd) begin
         case (address[1:0])
            2'd1:    read_data_d = status_word;
            2'd2:    read_data_d = divisor_q;
            default: read_data_d = 16'h0000;
         endcase
      end
   end

   // Serializer: each symbol is held for bit_div_q+1 clocks; tx_d is the level after this edge.
   assign bit_end = (div_cnt_q == bit_div_q);

   always_comb begin
      state_d   = state_q;
      bit_div_d = bit_div_q;
      div_cnt_d = div_cnt_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (!empty) begin
               shift_d   = fifo_mem[rd_ptr_q];
               bit_div_d = divisor_q;
               div_cnt_d = 16'd0;
               bit_cnt_d = 3'd0;
               tx_d      = 1'b0;
               state_d   = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               div_cnt_d = 16'd0;
               tx_d      = shift_q[0];
               state_d   = S_DATA;
            end else begin
               div_cnt_d = div_cnt_q + 16'd1;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               div_cnt_d = 16'd0;
               if (bit_cnt_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = S_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  shift_d   = {1'b0, shift_q[7:1]};
                  tx_d      = shift_q[1];
               end
            end else begin
               div_cnt_d = div_cnt_q + 16'd1;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               tx_d    = 1'b1;
               state_d = S_IDLE;
            end else begin
               div_cnt_d = div_cnt_q + 16'd1;
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (push_ok) fifo_mem[wr_ptr_q] <= write_data[7:0];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         divisor_q   <= DEFAULT_DIVISOR;
         bit_div_q   <= DEFAULT_DIVISOR;
         div_cnt_q   <= 16'd0;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 8'h00;
         tx_q        <= 1'b1;
         read_data_q <= 16'h0000;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         divisor_q   <= divisor_d;
         bit_div_q   <= bit_div_d;
         div_cnt_q   <= div_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         tx_q        <= tx_d;
         read_data_q <= read_data_d;
      end
   end

   assign tx        = tx_q;
   assign read_data = read_data_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed and randomized bench for mmio_uart_tx; the serial line is logged every clock and
// compared against an ideal 8N1 waveform built from the bytes and per-frame divisors.
module tb_mmio_uart_tx;

   typedef logic [7:0] byte_q_t[$];
   typedef int         int_q_t[$];

   logic        clock = 1'b0;
   logic        reset;
   logic        select, read_enable, write_enable;
   logic [15:0] address, write_data, read_data;
   logic        tx;
`ifdef MMIO_UART_TX_IRQ_EN
   logic        irq;
`endif

   int checks   = 0;
   int failures = 0;

   bit rec_en = 1'b0;
   bit tx_log[$];

   mmio_uart_tx dut (
      .clock(clock), .reset(reset), .select(select), .read_enable(read_enable),
      .write_enable(write_enable), .address(address), .write_data(write_data),
      .read_data(read_data), .tx(tx)
`ifdef MMIO_UART_TX_IRQ_EN
      , .irq(irq)
`endif
   );

   always #5 clock = ~clock;

   // Line level just after every rising edge while recording.
   always @(posedge clock) begin
      #1;
      if (rec_en) tx_log.push_back(tx);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Bus tasks are entered on a falling edge and return on the next one, so calls chain back to back.
   task automatic bus_op(input logic rd, input logic wr, input logic [1:0] a,
                         input logic [15:0] wd, output logic [15:0] rdv);
      select = 1'b1; read_enable = rd; write_enable = wr;
      address = {14'd0, a}; write_data = wd;
      @(negedge clock);
      select = 1'b0; read_enable = 1'b0; write_enable = 1'b0;
      rdv = read_data;
   endtask

   task automatic wr(input logic [1:0] a, input logic [15:0] wd);
      logic [15:0] dummy;
      bus_op(1'b0, 1'b1, a, wd, dummy);
   endtask

   task automatic rd(input logic [1:0] a, output logic [15:0] rdv);
      bus_op(1'b1, 1'b0, a, 16'h0000, rdv);
   endtask

   // Recording starts at the falling edge before the first push edge: one idle sample, then each
   // frame (start 0, 8 data bits LSB first, stop 1, each divisor+1 clocks) followed by one idle clock.
   task automatic check_frames(input string tag, input byte_q_t bytes, input int_q_t divs);
      bit exp_q[$];
      int guard = 0;
      int errs  = 0;
      int first = -1;
      bit v;
      exp_q.push_back(1'b1);
      foreach (bytes[f]) begin
         for (int s = 0; s < 10; s++) begin
            v = (s == 0) ? 1'b0 : (s == 9) ? 1'b1 : bytes[f][s-1];
            repeat (divs[f] + 1) exp_q.push_back(v);
         end
         exp_q.push_back(1'b1);
      end
      while (tx_log.size() < exp_q.size() && guard < 20000) begin
         @(negedge clock);
         guard++;
      end
      foreach (exp_q[i]) begin
         if (i >= tx_log.size() || tx_log[i] !== exp_q[i]) begin
            errs++;
            if (first < 0) first = i;
         end
      end
      check($sformatf("%s wrong_samples(first_at=%0d)", tag, first), errs, 0);
      rec_en = 1'b0;
      tx_log.delete();
   endtask

   initial begin
      logic [15:0] r;
      byte_q_t     bq;
      int_q_t      dq;
      int          d, n;

      reset = 1'b1; select = 1'b0; read_enable = 1'b0; write_enable = 1'b0;
      address = 16'h0000; write_data = 16'h0000;
      repeat (3) @(negedge clock);
      check("reset_tx", tx, 1'b1);
      check("reset_read_data", read_data, 16'h0000);
      reset = 1'b0;
      @(negedge clock);

      rd(2'd1, r); check("status_after_reset", r, 16'h0004);
      rd(2'd2, r); check("divisor_default", r, 16'd103);

      // Strobes without select are ignored.
      select = 1'b0; write_enable = 1'b1; address = 16'h0000; write_data = 16'h0077;
      @(negedge clock);
      write_enable = 1'b0;
      repeat (2) @(negedge clock);
      check("unselected_tx_idle", tx, 1'b1);
      rd(2'd1, r); check("unselected_no_push", r, 16'h0004);
      rd(2'd3, r); check("reserved_read", r, 16'h0000);
      rd(2'd0, r); check("data_read", r, 16'h0000);

      // Simultaneous read/write returns the pre-write value; read_data then holds.
      wr(2'd2, 16'd3);
      bus_op(1'b1, 1'b1, 2'd2, 16'h1234, r); check("rw_returns_old", r, 16'd3);
      wr(2'd3, 16'hFFFF);
      @(negedge clock);
      check("read_data_holds", read_data, 16'd3);
      rd(2'd2, r); check("rw_write_done", r, 16'h1234);

      // Single byte, divisor 3.
      wr(2'd2, 16'd3);
      rec_en = 1'b1;
      wr(2'd0, 16'h1255);
      check("tx_high_after_push_edge", tx, 1'b1);
      bq = '{8'h55}; dq = '{3};
      check_frames("single_byte_55", bq, dq);
      rd(2'd1, r); check("status_after_single", r, 16'h0004);

      // Back-to-back at divisor 0.
      wr(2'd2, 16'd0);
      rec_en = 1'b1;
      wr(2'd0, 16'h00A5);
      wr(2'd0, 16'h003C);
      bq = '{8'hA5, 8'h3C}; dq = '{0, 0};
      check_frames("back_to_back_div0", bq, dq);

      // Divisor change mid-frame only affects the next frame.
      wr(2'd2, 16'd3);
      rec_en = 1'b1;
      wr(2'd0, 16'h00C3);
      wr(2'd0, 16'h0096);
      wr(2'd2, 16'd1);
      bq = '{8'hC3, 8'h96}; dq = '{3, 1};
      check_frames("divisor_change", bq, dq);

      // Burst of 10 pushes: one goes to the shifter, eight fill the FIFO, the tenth overflows.
      wr(2'd2, 16'd3);
      rec_en = 1'b1;
      bq.delete(); dq.delete();
      for (int i = 1; i <= 10; i++) wr(2'd0, 16'(i));
      rd(2'd1, r); check("burst_status", r, 16'h080B);
      rd(2'd1, r); check("burst_status_ovf_cleared", r, 16'h0803);
      for (int i = 1; i <= 9; i++) begin
         bq.push_back(8'(i));
         dq.push_back(3);
      end
      check_frames("burst_frames", bq, dq);
      rd(2'd1, r); check("status_after_burst", r, 16'h0004);

      // Randomized bursts.
      for (int k = 0; k < 3; k++) begin
         d = $urandom_range(0, 4);
         n = $urandom_range(2, 6);
         wr(2'd2, 16'(d));
         bq.delete(); dq.delete();
         rec_en = 1'b1;
         for (int i = 0; i < n; i++) begin
            bq.push_back(8'($urandom_range(0, 255)));
            dq.push_back(d);
            wr(2'd0, {8'($urandom_range(0, 255)), bq[i]});
         end
         check_frames($sformatf("random_%0d_div%0d_n%0d", k, d, n), bq, dq);
         rd(2'd1, r); check($sformatf("random_%0d_status", k), r, 16'h0004);
      end

      // Asynchronous reset in the middle of a frame.
      wr(2'd2, 16'd3);
      rd(2'd2, r);
      wr(2'd0, 16'h0000);
      repeat (12) @(negedge clock);
      check("midframe_tx_low", tx, 1'b0);
      #2 reset = 1'b1;
      #1 check("async_reset_tx", tx, 1'b1);
      check("async_reset_read_data", read_data, 16'h0000);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      check("post_reset_tx_idle", tx, 1'b1);
      rd(2'd1, r); check("post_reset_status", r, 16'h0004);
      rd(2'd2, r); check("post_reset_divisor", r, 16'd103);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
